// File: rtl/pipelined_cla_adder_pkg.sv
// Shared ALU constants for the adder and the ALU decoder.
package pipelined_cla_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// N-bit carry-lookahead cell: group generate/propagate plus the
// carry into every bit, all in flat sum-of-products form.
module cla_group #(
    parameter int N = 4
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    input  logic         c,
    output logic         G,
    output logic         P,
    output logic [N-1:0] C
);

    // Carry into bit i: c & p[0..i-1] | OR_k g[k] & p[k+1..i-1].
    // With i == N and c == 0 this is exactly the group generate.
    function automatic logic carry_into(
        input logic [N-1:0] gv,
        input logic [N-1:0] pv,
        input logic         cv,
        input int           i
    );
        logic r;
        logic t;
        r = cv;
        for (int j = 0; j < i; j++) r = r & pv[j];
        for (int k = 0; k < i; k++) begin
            t = gv[k];
            for (int j = k + 1; j < i; j++) t = t & pv[j];
            r = r | t;
        end
        return r;
    endfunction

    always_comb begin
        C = '0;
        for (int i = 0; i < N; i++) C[i] = carry_into(g, p, c, i);
        G = carry_into(g, p, 1'b0, N);
        P = &p;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with flags
// and a valid/ready handshake; the whole pipe stalls together.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    logic             adv;
    logic [WIDTH-1:0] b_eff, g_d, p_d;
    logic             c0_d;
    logic [NG-1:0]    gg_d, gp_d;
    logic [WIDTH-1:0] s1_cy_unused;

    logic             s1_valid_q, c0_q;
    logic [WIDTH-1:0] g_q, p_q;
    logic [NG-1:0]    gg_q, gp_q;

    logic [NG-1:0]    grp_cy;
    logic             word_g, word_p;
    logic [NG-1:0]    s2_g_unused, s2_p_unused;
    logic [WIDTH-1:0] cy;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, zero_d;

    logic             out_valid_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] sum_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c0_d  = (op == OP_SUB) ? 1'b1 : cin;
    assign g_d   = a & b_eff;
    assign p_d   = a ^ b_eff;

    // Stage 1 needs only group G/P; in-group carries wait for stage 2.
    for (genvar k = 0; k < NG; k++) begin : g_s1
        cla_group #(.N(GROUP)) u_grp (
            .g (g_d[k*GROUP +: GROUP]),
            .p (p_d[k*GROUP +: GROUP]),
            .c (1'b0),
            .G (gg_d[k]),
            .P (gp_d[k]),
            .C (s1_cy_unused[k*GROUP +: GROUP])
        );
    end

    cla_group #(.N(NG)) u_top (
        .g (gg_q),
        .p (gp_q),
        .c (c0_q),
        .G (word_g),
        .P (word_p),
        .C (grp_cy)
    );

    for (genvar k = 0; k < NG; k++) begin : g_s2
        cla_group #(.N(GROUP)) u_grp (
            .g (g_q[k*GROUP +: GROUP]),
            .p (p_q[k*GROUP +: GROUP]),
            .c (grp_cy[k]),
            .G (s2_g_unused[k]),
            .P (s2_p_unused[k]),
            .C (cy[k*GROUP +: GROUP])
        );
    end

    assign sum_d  = p_q ^ cy;
    assign cout_d = word_g | (word_p & c0_q);
    assign ovf_d  = cy[WIDTH-1] ^ cout_d;
    assign zero_d = ~|sum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            c0_q        <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            c0_q        <= c0_d;
            g_q         <= g_d;
            p_q         <= p_d;
            gg_q        <= gg_d;
            gp_q        <= gp_d;
            out_valid_q <= s1_valid_q;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder (32-bit and 16-bit).
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [15:0] a16, b16;

    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    assign a16 = a[15:0];
    assign b16 = b[15:0];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin), .op(op),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    typedef struct {
        logic        op;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on a w-bit word using wide integer addition.
    function automatic void model(input int w, input logic [31:0] x,
                                  input logic [31:0] y, input logic ci,
                                  input logic o, output logic [31:0] s,
                                  output logic co, output logic ov,
                                  output logic z);
        logic [32:0] mask, xe, be, full, sm;
        mask = (33'd1 << w) - 33'd1;
        xe   = {1'b0, x} & mask;
        be   = o ? (~{1'b0, y}) & mask : {1'b0, y} & mask;
        full = xe + be + {32'd0, (o ? 1'b1 : ci)};
        sm   = full & mask;
        s    = sm[31:0];
        co   = full[w];
        ov   = (xe[w-1] == be[w-1]) && (sm[w-1] != xe[w-1]);
        z    = (sm == 33'd0);
    endfunction

    task automatic drive(input logic v, input logic o, input logic ci,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = v;
        op       = o;
        cin      = ci;
        a        = x;
        b        = y;
    endtask

    task automatic chk_out(input string nm, input logic [31:0] s,
                           input logic co, input logic ov, input logic z);
        chk({nm, " valid"}, 32'(out_valid), 32'd1);
        chk({nm, " sum"}, sum, s);
        chk({nm, " cout"}, 32'(cout), 32'(co));
        chk({nm, " ovf"}, 32'(ovf), 32'(ov));
        chk({nm, " zero"}, 32'(zero), 32'(z));
    endtask

    logic [31:0] es[8];
    logic        ec[8], eo[8], ez[8];
    logic [31:0] ms;
    logic        mc, mo, mz;
    logic [31:0] hold_sum;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000001, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst sum", sum, 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Table vectors, one at a time, checking exact 2-cycle latency
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].op, vt[i].cin, vt[i].a, vt[i].b);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("v%0d early", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            chk_out($sformatf("v%0d", i), vt[i].sum, vt[i].cout,
                    vt[i].ovf, vt[i].zero);
            model(16, vt[i].a, vt[i].b, vt[i].cin, vt[i].op,
                  ms, mc, mo, mz);
            chk($sformatf("w16 v%0d valid", i), 32'(out_valid16), 32'd1);
            chk($sformatf("w16 v%0d sum", i), 32'(sum16), ms);
            chk($sformatf("w16 v%0d cout", i), 32'(cout16), 32'(mc));
            chk($sformatf("w16 v%0d ovf", i), 32'(ovf16), 32'(mo));
            chk($sformatf("w16 v%0d zero", i), 32'(zero16), 32'(mz));
        end

        // Back-to-back stream of 8 random ops
        for (int m = 0; m < 10; m++) begin
            @(negedge clk);
            if (m >= 2)
                chk_out($sformatf("strm%0d", m - 2), es[m-2], ec[m-2],
                        eo[m-2], ez[m-2]);
            if (m < 8) begin
                drive(1'b1, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom);
                model(32, a, b, cin, op, es[m], ec[m], eo[m], ez[m]);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end

        // Backpressure with two ops in flight
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h00000010, 32'h00000020);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h00000100, 32'h00000001);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        #1;
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk_out("bp A", 32'h00000030, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            chk_out($sformatf("bp%0d hold", k), 32'h00000030, 1'b0,
                    1'b0, 1'b0);
            drive(1'b1, 1'b1, 1'b1, $urandom, $urandom);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp B", 32'h000000FF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp no dup", 32'(out_valid), 32'd0);

        // Async reset mid-stream
        drive(1'b1, 1'b0, 1'b0, 32'h00000011, 32'h00000022);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h00000033, 32'h00000044);
        @(posedge clk);
        #2;
        hold_sum = sum;
        chk("pre-rst sum", hold_sum, 32'h00000033);
        rst = 1'b1;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst sum", sum, 32'd0);
        chk("arst cout", 32'(cout), 32'd0);
        chk("arst ovf", 32'(ovf), 32'd0);
        chk("arst zero", 32'(zero), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst idle%0d", k), 32'(out_valid), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h00000003, 32'h00000004);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("recover early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_out("recover", 32'h00000008, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
